// File: rtl/vissue_sched_pkg.sv
// Shared types and constants for the vector issue scheduler.
package vissue_sched_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } vsched_state_t;

  localparam int unsigned RSVD_TICKET = 0;

endpackage

// File: rtl/vissue_sched_vticket_bitmap.sv
// In-flight ticket bitmap: one set port, two clear ports, alias lookup,
// population count and empty flag. Bit 0 (the reserved ticket) has no storage.
module vticket_bitmap
  import vissue_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         set_en,
  input  logic [N-1:0] set_idx,
  input  logic         clr_a_en,
  input  logic [N-1:0] clr_a_idx,
  input  logic         clr_b_en,
  input  logic [N-1:0] clr_b_idx,
  input  logic [N-1:0] query_idx,
  output logic         query_hit,
  output logic         clr_a_hit,
  output logic         clr_b_hit,
  output logic [N-1:0] popcnt,
  output logic         empty
);

  localparam int DEPTH = 1 << N;

  logic [DEPTH-1:1] bits_q;
  logic [DEPTH-1:1] bits_d;
  logic [DEPTH-1:0] map_full;

  // Reserved ticket reads as never in flight, so it neither aliases nor retires.
  assign map_full  = {bits_q, 1'b0};
  assign query_hit = map_full[query_idx];
  assign clr_a_hit = map_full[clr_a_idx];
  assign clr_b_hit = map_full[clr_b_idx];
  assign empty     = ~|bits_q;

  always_comb begin
    bits_d = bits_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (clr_a_en && clr_a_hit && int'(clr_a_idx) == i) bits_d[i] = 1'b0;
      if (clr_b_en && clr_b_hit && int'(clr_b_idx) == i) bits_d[i] = 1'b0;
      if (set_en && int'(set_idx) == i && int'(set_idx) != int'(RSVD_TICKET))
        bits_d[i] = 1'b1;
    end
  end

  always_comb begin
    popcnt = '0;
    for (int i = 1; i < DEPTH; i++) popcnt = popcnt + N'(bits_q[i]);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) bits_q <= '0;
    else         bits_q <= bits_d;
  end

endmodule

// File: rtl/vissue_sched.sv
// Vector issue scheduler: ticket alias, memory cap and reconfigure drain gating.
// Optional stall performance counter enabled by defining VISSUE_SCHED_PERF_EN.
module vissue_sched
  import vissue_sched_pkg::*;
#(
  parameter int VECTOR_TICKET_BITS = 4,
  parameter int MAX_MEM_INFLIGHT   = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          cand_valid_i,
  input  logic                          cand_reconfig_i,
  input  logic                          cand_mem_i,
  input  logic [VECTOR_TICKET_BITS-1:0] cand_ticket_i,
  input  logic                          fire_i,
  input  logic                          ex_ready_i,
  input  logic                          mem_ready_i,
  output logic                          ex_ready_o,
  output logic                          mem_ready_o,
  input  logic                          ex_retire_i,
  input  logic [VECTOR_TICKET_BITS-1:0] ex_retire_ticket_i,
  input  logic                          mem_retire_i,
  input  logic [VECTOR_TICKET_BITS-1:0] mem_retire_ticket_i,
  output logic [VECTOR_TICKET_BITS-1:0] inflight_o,
  output logic                          draining_o,
  output logic                          idle_o,
  output logic                          err_o,
  output logic [31:0]                   stall_cycles_o
);

  localparam int CW = $clog2(MAX_MEM_INFLIGHT + 1);

  vsched_state_t state_q, state_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          err_q;
  logic          alias_hit, ex_hit, mem_hit, empty;
  logic          set_en, mem_inc, mem_dec, block;

  assign set_en = fire_i & ~cand_reconfig_i;

  vticket_bitmap #(.N(VECTOR_TICKET_BITS)) u_bitmap (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .set_en    (set_en),
    .set_idx   (cand_ticket_i),
    .clr_a_en  (ex_retire_i),
    .clr_a_idx (ex_retire_ticket_i),
    .clr_b_en  (mem_retire_i),
    .clr_b_idx (mem_retire_ticket_i),
    .query_idx (cand_ticket_i),
    .query_hit (alias_hit),
    .clr_a_hit (ex_hit),
    .clr_b_hit (mem_hit),
    .popcnt    (inflight_o),
    .empty     (empty)
  );

  assign block = alias_hit
               | (cand_mem_i && mem_cnt_q == CW'(MAX_MEM_INFLIGHT))
               | (cand_reconfig_i & ~empty)
               | (state_q == DRAIN && !empty);

  assign ex_ready_o  = ex_ready_i & ~block;
  assign mem_ready_o = mem_ready_i & ~block;
  assign draining_o  = (state_q == DRAIN);
  assign idle_o      = empty & ~cand_valid_i;
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cand_valid_i && cand_reconfig_i && !empty) state_d = DRAIN;
      DRAIN:   if (empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // A bogus mem retire changes nothing; a real one never takes the count below 0.
  assign mem_inc   = set_en & cand_mem_i;
  assign mem_dec   = mem_retire_i & mem_hit & (mem_cnt_q != '0);
  assign mem_cnt_d = mem_cnt_q + CW'(mem_inc) - CW'(mem_dec);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RUN;
      mem_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      err_q     <= err_q | (ex_retire_i & ~ex_hit) | (mem_retire_i & ~mem_hit);
    end
  end

`ifdef VISSUE_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                      stall_q <= '0;
    else if (cand_valid_i && block && stall_q != '1)  stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_vissue_sched.sv
// Scoreboard bench for vissue_sched: reference model of tickets, memory cap and drain.
module tb_vissue_sched;

  localparam int N    = 4;
  localparam int NT   = 1 << N;
  localparam int MAXM = 2;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         cand_valid_i = 1'b0, cand_reconfig_i = 1'b0, cand_mem_i = 1'b0;
  logic [N-1:0] cand_ticket_i = '0;
  logic         fire_i = 1'b0, ex_ready_i = 1'b1, mem_ready_i = 1'b0;
  logic         ex_ready_o, mem_ready_o;
  logic         ex_retire_i = 1'b0, mem_retire_i = 1'b0;
  logic [N-1:0] ex_retire_ticket_i = '0, mem_retire_ticket_i = '0;
  logic [N-1:0] inflight_o;
  logic         draining_o, idle_o, err_o;
  logic [31:0]  stall_cycles_o;

  vissue_sched #(.VECTOR_TICKET_BITS(N), .MAX_MEM_INFLIGHT(MAXM)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cand_valid_i(cand_valid_i), .cand_reconfig_i(cand_reconfig_i),
    .cand_mem_i(cand_mem_i), .cand_ticket_i(cand_ticket_i), .fire_i(fire_i),
    .ex_ready_i(ex_ready_i), .mem_ready_i(mem_ready_i),
    .ex_ready_o(ex_ready_o), .mem_ready_o(mem_ready_o),
    .ex_retire_i(ex_retire_i), .ex_retire_ticket_i(ex_retire_ticket_i),
    .mem_retire_i(mem_retire_i), .mem_retire_ticket_i(mem_retire_ticket_i),
    .inflight_o(inflight_o), .draining_o(draining_o), .idle_o(idle_o),
    .err_o(err_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit      ex_ready;
    bit      mem_ready;
    int      inflight;
    bit      draining;
    bit      idle;
    bit      err;
    longint  stall;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a set of busy tickets, which of them are memory ops,
  // the number of outstanding memory ops, and whether we are draining.
  bit     busy[NT];
  bit     is_mem[NT];
  int     mem_n;
  bit     drain;
  bit     err_m;
  longint stall_m;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int n_busy();
    int c = 0;
    for (int i = 1; i < NT; i++) c += int'(busy[i]);
    return c;
  endfunction

  function automatic bit model_block(bit rc, bit mem, int tkt);
    return (tkt != 0 && busy[tkt]) || (mem && mem_n == MAXM) ||
           (rc && n_busy() != 0) || (drain && n_busy() != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin busy[i] = 0; is_mem[i] = 0; end
    mem_n = 0; drain = 0; err_m = 0; stall_m = 0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_ready",  longint'(ex_ready_o),  longint'(e.ex_ready));
      chk("mem_ready", longint'(mem_ready_o), longint'(e.mem_ready));
      chk("inflight",  longint'(inflight_o),  longint'(e.inflight));
      chk("draining",  longint'(draining_o),  longint'(e.draining));
      chk("idle",      longint'(idle_o),      longint'(e.idle));
      chk("err",       longint'(err_o),       longint'(e.err));
      chk("stall",     longint'(stall_cycles_o), e.stall);
    end
  end

  // One clock cycle: drive, predict, hand prediction to the monitor, advance model.
  task automatic step(input bit cv, input bit rc, input bit mem, input int tkt,
                      input bit fire, input bit exr, input bit memr,
                      input bit xr, input int xt, input bit mr, input int mt);
    exp_t e;
    bit   blk, drain_nx;
    cand_valid_i = cv; cand_reconfig_i = rc; cand_mem_i = mem;
    cand_ticket_i = N'(tkt); fire_i = fire;
    ex_ready_i = exr; mem_ready_i = memr;
    ex_retire_i = xr; ex_retire_ticket_i = N'(xt);
    mem_retire_i = mr; mem_retire_ticket_i = N'(mt);
    blk = model_block(rc, mem, tkt);
    e.ex_ready = exr && !blk;
    e.mem_ready = memr && !blk;
    e.inflight = n_busy();
    e.draining = drain;
    e.idle = (n_busy() == 0) && !cv;
    e.err = err_m;
    e.stall = stall_m;
    q.push_back(e);
    @(posedge clk_i);
`ifdef VISSUE_SCHED_PERF_EN
    if (cv && blk) stall_m++;
`endif
    drain_nx = (n_busy() != 0) && (drain || (cv && rc));
    if (xr) begin
      if (xt != 0 && busy[xt]) busy[xt] = 0; else err_m = 1;
    end
    if (mr) begin
      if (mt != 0 && busy[mt]) begin
        busy[mt] = 0;
        if (mem_n > 0) mem_n--;
      end else err_m = 1;
    end
    if (fire && !rc) begin
      if (tkt != 0) begin busy[tkt] = 1; is_mem[tkt] = mem; end
      if (mem) mem_n++;
    end
    drain = drain_nx;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic fire_op(input bit mem, input int tkt);
    step(1, 0, mem, tkt, 1, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cand_valid_i = 0; fire_i = 0; ex_retire_i = 0; mem_retire_i = 0;
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_inflight", longint'(inflight_o), 0);
    chk("rst_draining", longint'(draining_o), 0);
    chk("rst_err",      longint'(err_o),      0);
    chk("rst_stall",    longint'(stall_cycles_o), 0);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int exl[$], ml[$];
    bit cv, rc, mem, exr, memr, fire, xr, mr;
    int tkt, xt, mt;

    model_reset();
    #12;
    chk("por_ex_ready",  longint'(ex_ready_o),  1);
    chk("por_mem_ready", longint'(mem_ready_o), 0);
    chk("por_idle",      longint'(idle_o),      1);
    chk("por_inflight",  longint'(inflight_o),  0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single op round trip
    fire_op(0, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    idle(1);

    // Fill every ticket, then alias on ticket 1 until it retires
    for (int t = 1; t < NT; t++) fire_op(0, t);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    for (int t = 2; t < NT; t++) step(0, 0, 0, 0, 0, 1, 1, 1, t, 0, 0);
    idle(1);

    // Memory cap
    fire_op(1, 3);
    fire_op(1, 4);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 5, 0, 1, 1, 0, 0, 1, 3);
    fire_op(1, 5);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 5);
    idle(1);

    // Reconfigure drain
    fire_op(0, 3);
    fire_op(0, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 6, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 6, 0, 1, 1, 1, 3, 0, 0);
    step(1, 1, 0, 6, 0, 1, 1, 1, 4, 0, 0);
    step(1, 1, 0, 6, 1, 1, 1, 0, 0, 0, 0);
    idle(2);
    chk("reconfig_empty", longint'(inflight_o), 0);

    // Bogus retires are sticky errors
    fire_op(1, 2);
    step(0, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0);
    idle(2);
    chk("err_sticky", longint'(err_o), 1);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2);
    idle(1);

    // Asynchronous reset in the middle of a drain
    fire_op(0, 2);
    fire_op(1, 6);
    step(1, 1, 0, 8, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 8, 0, 1, 1, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 6);
    idle(1);

    // Ten-cycle alias stall
    do_reset();
    fire_op(0, 5);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0);
`ifdef VISSUE_SCHED_PERF_EN
    chk("perf_stall10", longint'(stall_cycles_o), 10);
`else
    chk("perf_stall10", longint'(stall_cycles_o), 0);
`endif
    step(0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0);
    idle(1);

    // Random traffic with legal fires and retires
    for (int c = 0; c < 3000; c++) begin
      exl.delete(); ml.delete();
      for (int i = 1; i < NT; i++)
        if (busy[i]) begin
          if (is_mem[i]) ml.push_back(i); else exl.push_back(i);
        end
      cv   = $urandom_range(0, 3) != 0;
      rc   = $urandom_range(0, 24) == 0;
      mem  = $urandom_range(0, 1) == 1;
      tkt  = $urandom_range(1, NT - 1);
      exr  = $urandom_range(0, 4) != 0;
      memr = $urandom_range(0, 4) != 0;
      fire = cv && (mem ? memr : exr) && !model_block(rc, mem, tkt) &&
             $urandom_range(0, 3) != 0;
      xr = exl.size() > 0 && $urandom_range(0, 2) == 0;
      xt = xr ? exl[$urandom_range(0, exl.size() - 1)] : 0;
      mr = ml.size() > 0 && $urandom_range(0, 2) == 0;
      mt = mr ? ml[$urandom_range(0, ml.size() - 1)] : 0;
      step(cv, rc, mem, tkt, fire, exr, memr, xr, xt, mr, mt);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vissue_sched.md
# vissue_sched

Issue scheduler placed between the vector instruction queue / register remapper and the vector execution and memory pipes. Tracks every in-flight ticket in a bitmap, so a ticket is never reissued while its previous holder is still outstanding. Caps outstanding memory operations and drains the machine before a reconfigure passes. It produces the gated ready signals the remapper consumes.

## Interface
- VECTOR_TICKET_BITS, 4: ticket width. Valid tickets are 1..2^N-1; 0 is reserved.
- MAX_MEM_INFLIGHT, 4: maximum outstanding load/store ops, 1..2^N-1.
- clk_i  in  1: clock.
- rstn_i  in  1: reset, asynchronous, active-low.
- cand_valid_i  in  1: a candidate instruction is presented to the remapper.
- cand_reconfig_i  in  1: the candidate is a reconfigure.
- cand_mem_i  in  1: the candidate is a load or store.
- cand_ticket_i  in  VECTOR_TICKET_BITS: ticket the remapper will assign to the candidate.
- fire_i  in  1: the remapper popped the candidate this cycle.
- ex_ready_i  in  1: execution pipe can accept.
- mem_ready_i  in  1: memory pipe can accept.
- ex_ready_o  out  1: gated ready to the remapper, execution path.
- mem_ready_o  out  1: gated ready to the remapper, memory path.
- ex_retire_i  in  1 / ex_retire_ticket_i  in  VECTOR_TICKET_BITS: a non-memory op completed.
- mem_retire_i  in  1 / mem_retire_ticket_i  in  VECTOR_TICKET_BITS: a load/store completed.
- inflight_o  out  VECTOR_TICKET_BITS: population count of the ticket bitmap.
- draining_o  out  1: FSM is in DRAIN.
- idle_o  out  1: bitmap is empty and cand_valid_i=0.
- err_o  out  1: sticky flag. Set on a retire of a ticket that is not in flight, or a retire of ticket 0.
- stall_cycles_o  out  32: performance counter (see Configuration).

## Operation
- State kept: inflight bitmap[2^N-1:1], mem_cnt, FSM {RUN, DRAIN}.
- Candidate block conditions (any one true):
  - cand_ticket_i bit already set in the bitmap (ticket alias);
  - cand_mem_i=1 and mem_cnt==MAX_MEM_INFLIGHT;
  - cand_reconfig_i=1 and bitmap≠0;
  - FSM=DRAIN and bitmap≠0.
- ex_ready_o = ex_ready_i & ~block.
- mem_ready_o = mem_ready_i & ~block.
- On fire_i with a non-reconfigure candidate:
  - set bitmap[cand_ticket_i];
  - if cand_mem_i=1, increment mem_cnt.
- A reconfigure fire sets nothing.
- On ex_retire_i: clear bitmap[ex_retire_ticket_i].
- On mem_retire_i: clear bitmap[mem_retire_ticket_i] and decrement mem_cnt.
- Both retires may occur in the same cycle, together with a fire. All updates are applied; fire sets and retire clears target distinct bits by construction.
- FSM transitions:
  - RUN→DRAIN when cand_valid_i & cand_reconfig_i & bitmap≠0.
  - DRAIN→RUN in the cycle after the bitmap becomes 0. The reconfigure can then fire.
- A retire that hits a clear bit or ticket 0 sets err_o and leaves state unchanged. mem_cnt never underflows; it saturates at 0.

## Timing
- Reset values:
  - bitmap=0, mem_cnt=0, FSM=RUN;
  - inflight_o=0, draining_o=0, err_o=0, stall_cycles_o=0;
  - idle_o=~cand_valid_i;
  - ready outputs follow their ready inputs (nothing is blocked at reset).
- Ready outputs are combinational from registered state and the current candidate inputs. Zero-cycle latency from ex_ready_i/mem_ready_i.
- Retires update registered state. Their effect on ready appears one cycle later; there is no same-cycle bypass.
- Back-to-back fires: one per cycle is supported.
- Ticket wrap 2^N-1→1: the scheduler needs no special handling. The alias check alone protects it.
- Reconfigure latency: at least one cycle after the last retire. It is zero extra cycles if the bitmap is already empty.
- An asynchronous reset mid-drain clears everything immediately. In-flight retires arriving afterwards set err_o.

## Configuration
- VISSUE_SCHED_PERF_EN defined:
  - stall_cycles_o counts cycles where cand_valid_i=1 and block=1;
  - the counter saturates at 2^32-1 and clears on reset.
- VISSUE_SCHED_PERF_EN undefined: stall_cycles_o is tied to 0 and no counter flops exist. The port list is identical in both builds.

## Structure
- The shared package holds:
  - a vsched_state_t enum {RUN, DRAIN};
  - the constant for the reserved ticket 0.
- Sub-module vticket_bitmap holds the set/clear bitmap, the alias lookup, popcount and empty flag.
- The FSM, mem counter and perf counter live in the top module.

## Test plan
- After reset, cand ticket 1 non-mem with ex_ready_i=1 → ex_ready_o=1. Fire, then inflight_o=1 next cycle. ex_retire ticket 1 → inflight_o=0 one cycle later.
- N=4, fire tickets 1..15 with no retires, then cand ticket 1 → ex_ready_o=0 until ex_retire ticket 1. Ready then rises on the following cycle.
- MAX_MEM_INFLIGHT=2, two mem fires, third mem candidate → mem_ready_o=0. mem_retire → mem_ready_o=1 next cycle.
- Tickets 3 and 4 in flight, reconfigure candidate arrives → draining_o=1 and both readies 0. Retire both → readies return one cycle after the bitmap is empty. Reconfigure fires and the bitmap stays 0.
- ex_retire ticket 7 while it is not in flight → err_o=1 and stays set. mem_cnt and bitmap are unchanged.
- With VISSUE_SCHED_PERF_EN, a 10-cycle alias stall → stall_cycles_o=10. Without the macro → 0.
